fpu_div16: RTL and testbench

//  Iterative IEEE-754 binary16 divider: fpuOut = fpuIn1 / fpuIn2. It is the inverse-operation companion to

---
 rtl/fpu_div16.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fpu_div16.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div16.sv
// fpu_div16: iterative IEEE-754 binary16 divider, fpuOut = fpuIn1 / fpuIn2.
// Restoring division produces 1 quotient bit per cycle. Rounding is round-to-nearest-even.
// It uses the same start/done handshake as fpuMul16.
// Ports:
//   clock        in   1   single clock, posedge
//   reset        in   1   synchronous, active-high; aborts any operation in flight
//   fpuIn1       in  16   dividend, latched when start is accepted in IDLE
//   fpuIn2       in  16   divisor, latched when start is accepted in IDLE
//   start        in   1   request, sampled only in IDLE
//   fpuOut       out 16   quotient, held until the next accepted start
//   done         out  1   one-cycle pulse, fpuOut/condCodes/statusFlags valid
//   condCodes    out  4   {N, Z, I, U}
//   statusFlags  out  5   {invalid, divByZero, overflow, underflow, inexact}
// Build option: FPU_DIV_SUBNORM_EN enables subnormal inputs and results.
//   When it is undefined, subnormal inputs are zero and tiny results flush to zero.
module fpu_div16 (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] fpuIn1,
    input  logic [15:0] fpuIn2,
    input  logic        start,
    output logic [15:0] fpuOut,
    output logic        done,
    output logic [3:0]  condCodes,
    output logic [4:0]  statusFlags
);
    localparam int unsigned QBITS = 13;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t             r_state;
    logic [15:0]        r_a, r_b;
    logic               r_sign;
    logic signed [6:0]  r_exp;
    logic [11:0]        r_rem;
    logic [10:0]        r_sig2;
    logic [12:0]        r_q;
    logic               r_sticky, r_tiny;
    logic [3:0]         r_cnt;

    // Return {unbiased-offset exponent, significand with hidden bit}.
    // A subnormal is renormalised so that bit 10 is set.
    function automatic logic [17:0] unpack_op(input logic [15:0] x);
        logic [10:0] sig;
        logic [6:0]  e;
        sig = {1'b1, x[9:0]};
        e   = {2'b00, x[14:10]};
`ifdef FPU_DIV_SUBNORM_EN
        if (x[14:10] == 5'd0) begin
            sig = {1'b0, x[9:0]};
            e   = 7'd1;
            for (int i = 0; i < 10; i++) begin
                if (!sig[10]) begin
                    sig = {sig[9:0], 1'b0};
                    e   = e - 7'd1;
                end
            end
        end
`endif
        return {e, sig};
    endfunction

    // Condition codes {N, Z, I, U}. N is suppressed for NaN.
    function automatic logic [3:0] cond_of(input logic [15:0] x);
        logic nan;
        nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
        return {x[15] & ~nan, x[14:0] == 15'd0, x[14:0] == 15'h7C00, nan};
    endfunction

    // Operand classification
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    assign w_a_nan  = (r_a[14:10] == 5'h1F) && (r_a[9:0] != 10'd0);
    assign w_b_nan  = (r_b[14:10] == 5'h1F) && (r_b[9:0] != 10'd0);
    assign w_a_snan = w_a_nan && !r_a[9];
    assign w_b_snan = w_b_nan && !r_b[9];
    assign w_a_inf  = (r_a[14:10] == 5'h1F) && (r_a[9:0] == 10'd0);
    assign w_b_inf  = (r_b[14:10] == 5'h1F) && (r_b[9:0] == 10'd0);
`ifdef FPU_DIV_SUBNORM_EN
    assign w_a_zero = (r_a[14:0] == 15'd0);
    assign w_b_zero = (r_b[14:0] == 15'd0);
`else
    assign w_a_zero = (r_a[14:10] == 5'd0);
    assign w_b_zero = (r_b[14:10] == 5'd0);
`endif

    // Unpack: align so that the quotient falls in [1,2)
    logic [17:0]       w_u1, w_u2;
    logic signed [6:0] w_e1, w_e2, w_exp;
    logic [10:0]       w_sig1, w_sig2;
    logic              w_sig1_lt, w_sign;
    logic [11:0]       w_rem0;
    assign w_u1      = unpack_op(r_a);
    assign w_u2      = unpack_op(r_b);
    assign w_e1      = w_u1[17:11];
    assign w_e2      = w_u2[17:11];
    assign w_sig1    = w_u1[10:0];
    assign w_sig2    = w_u2[10:0];
    assign w_sig1_lt = (w_sig1 < w_sig2);
    assign w_sign    = r_a[15] ^ r_b[15];
    assign w_exp     = w_e1 - w_e2 + 7'sd15 - (w_sig1_lt ? 7'sd1 : 7'sd0);
    assign w_rem0    = w_sig1_lt ? {w_sig1, 1'b0} : {1'b0, w_sig1};

    // Special-operand result, in priority order
    logic        w_special;
    logic [15:0] w_spec_res;
    logic [4:0]  w_spec_flags;
    always_comb begin
        w_special    = 1'b1;
        w_spec_res   = 16'h0000;
        w_spec_flags = 5'b00000;
        if (w_a_nan || w_b_nan) begin
            w_spec_res   = 16'h7E00;
            w_spec_flags = {w_a_snan | w_b_snan, 4'b0000};
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res   = 16'h7E00;
            w_spec_flags = 5'b10000;
        end else if (w_a_inf) begin
            w_spec_res   = {w_sign, 15'h7C00};
        end else if (w_b_inf) begin
            w_spec_res   = {w_sign, 15'h0000};
        end else if (w_b_zero) begin
            w_spec_res   = {w_sign, 15'h7C00};
            w_spec_flags = 5'b01000;
        end else if (w_a_zero) begin
            w_spec_res   = {w_sign, 15'h0000};
        end else begin
            w_special    = 1'b0;
        end
    end

    // One restoring step: keep the trial difference only when non-negative
    logic [12:0] w_diff;
    logic [11:0] w_rem_next;
    assign w_diff     = {1'b0, r_rem} - {2'b00, r_sig2};
    assign w_rem_next = w_diff[12] ? r_rem : w_diff[11:0];

`ifdef FPU_DIV_SUBNORM_EN
    // Denormalising shift for tiny results. Shifted-out bits fold into sticky.
    logic [3:0]  w_sh;
    logic [27:0] w_wide;
    assign w_sh   = (r_exp <= -7'sd14) ? 4'd15 : 4'(7'sd1 - r_exp);
    assign w_wide = {r_q, 15'd0} >> w_sh;
`endif

    // RNE on {guard, round|sticky}. The hidden bit adds back the exponent minus one,
    // so a mantissa carry-out propagates straight into the exponent field.
    logic        w_guard, w_rs, w_inexact, w_up, w_ovf;
    logic [14:0] w_packed;
    logic [15:0] w_res;
    logic [4:0]  w_flags;
    assign w_guard   = r_q[1];
    assign w_rs      = r_q[0] | r_sticky;
    assign w_inexact = w_guard | w_rs;
    assign w_up      = w_guard & (w_rs | r_q[2]);
    assign w_packed  = {r_exp[4:0] - 5'd1, 10'd0} + {4'd0, r_q[12:2]} + {14'd0, w_up};
    assign w_ovf     = (r_exp >= 7'sd31) || (w_packed[14:10] == 5'h1F);

    always_comb begin
        w_res   = {r_sign, w_packed};
        w_flags = {4'b0000, w_inexact};
`ifdef FPU_DIV_SUBNORM_EN
        w_flags[1] = r_tiny & w_inexact;
        if (w_ovf) begin
            w_res   = {r_sign, 15'h7C00};
            w_flags = 5'b00101;
        end
`else
        if (r_tiny) begin
            w_res   = {r_sign, 15'h0000};
            w_flags = 5'b00011;
        end else if (w_ovf) begin
            w_res   = {r_sign, 15'h7C00};
            w_flags = 5'b00101;
        end
`endif
    end

    // Control FSM and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_sign      <= 1'b0;
            r_exp       <= 7'sd0;
            r_rem       <= 12'd0;
            r_sig2      <= 11'd0;
            r_q         <= 13'd0;
            r_sticky    <= 1'b0;
            r_tiny      <= 1'b0;
            r_cnt       <= 4'd0;
            fpuOut      <= 16'h0000;
            done        <= 1'b0;
            condCodes   <= 4'd0;
            statusFlags <= 5'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= fpuIn1;
                        r_b     <= fpuIn2;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        fpuOut      <= w_spec_res;
                        statusFlags <= w_spec_flags;
                        condCodes   <= cond_of(w_spec_res);
                        done        <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_rem   <= w_rem0;
                        r_sig2  <= w_sig2;
                        r_exp   <= w_exp;
                        r_q     <= 13'd0;
                        r_cnt   <= 4'd0;
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_q   <= {r_q[11:0], ~w_diff[12]};
                    r_rem <= 12'({w_rem_next, 1'b0});
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(QBITS - 1)) r_state <= S_NORM;
                end
                S_NORM: begin
`ifdef FPU_DIV_SUBNORM_EN
                    if (r_exp <= 7'sd0) begin
                        r_q      <= w_wide[27:15];
                        r_sticky <= (|r_rem) | (|w_wide[14:0]);
                        r_exp    <= 7'sd1;
                        r_tiny   <= 1'b1;
                    end else begin
                        r_sticky <= |r_rem;
                        r_tiny   <= 1'b0;
                    end
`else
                    r_sticky <= |r_rem;
                    r_tiny   <= (r_exp <= 7'sd0);
`endif
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    fpuOut      <= w_res;
                    statusFlags <= w_flags;
                    condCodes   <= cond_of(w_res);
                    done        <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_div16.sv
// tb_fpu_div16: self-checking bench for fpu_div16.
// It runs directed cases and then random operands against a rational-arithmetic reference model.
module tb_fpu_div16;
    logic        clock;
    logic        reset;
    logic [15:0] fpuIn1, fpuIn2;
    logic        start;
    logic [15:0] fpuOut;
    logic        done;
    logic [3:0]  condCodes;
    logic [4:0]  statusFlags;

    int checks = 0;
    int errors = 0;

    fpu_div16 dut (
        .clock(clock), .reset(reset), .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .start(start),
        .fpuOut(fpuOut), .done(done), .condCodes(condCodes), .statusFlags(statusFlags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cc_ref(input logic [15:0] r);
        logic nan;
        nan = (r[14:10] == 5'h1F) && (r[9:0] != 10'd0);
        return {nan ? 1'b0 : r[15], r[14:0] == 15'd0, r[14:0] == 15'h7C00, nan};
    endfunction

    // Reference: {special, flags, result}. It uses an exact integer quotient and generic RNE.
    function automatic logic [21:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic sgn, an, bn, asn, bsn, ai, bi, az, bz, stk, ix, up;
        logic [63:0] num, q, rb, half, mant;
        int ma, mb, ea, eb, x, p, be, sh, e;
        sgn = a[15] ^ b[15];
        an  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        bn  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        asn = an && !a[9];
        bsn = bn && !b[9];
        ai  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        bi  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
`ifdef FPU_DIV_SUBNORM_EN
        az = (a[14:0] == 15'd0);
        bz = (b[14:0] == 15'd0);
`else
        az = (a[14:10] == 5'd0);
        bz = (b[14:10] == 5'd0);
`endif
        if (an || bn) return {1'b1, (asn || bsn) ? 5'b10000 : 5'b00000, 16'h7E00};
        if ((az && bz) || (ai && bi)) return {1'b1, 5'b10000, 16'h7E00};
        if (ai) return {1'b1, 5'b00000, sgn, 15'h7C00};
        if (bi) return {1'b1, 5'b00000, sgn, 15'h0000};
        if (bz) return {1'b1, 5'b01000, sgn, 15'h7C00};
        if (az) return {1'b1, 5'b00000, sgn, 15'h0000};
        ma = (a[14:10] == 5'd0) ? int'(a[9:0]) : int'(a[9:0]) + 1024;
        mb = (b[14:10] == 5'd0) ? int'(b[9:0]) : int'(b[9:0]) + 1024;
        ea = (a[14:10] == 5'd0) ? -24 : int'(a[14:10]) - 25;
        eb = (b[14:10] == 5'd0) ? -24 : int'(b[14:10]) - 25;
        num = 64'(ma) << 24;
        q   = num / 64'(mb);
        stk = (num % 64'(mb)) != 64'd0;
        x   = ea - eb - 24;
        p   = 0;
        for (int k = 0; k < 64; k++) if (q[k]) p = k;
        be = p + x + 15;
        if (be >= 31) return {1'b0, 5'b00101, sgn, 15'h7C00};
`ifndef FPU_DIV_SUBNORM_EN
        if (be <= 0) return {1'b0, 5'b00011, sgn, 15'h0000};
`endif
        sh   = (be >= 1) ? p - 10 : -24 - x;
        mant = q >> sh;
        rb   = q & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        ix   = (rb != 64'd0) || stk;
        up   = (rb > half) || ((rb == half) && (stk || mant[0]));
        mant = mant + 64'(up);
        if (be >= 1) begin
            e = be;
            if (mant == 64'd2048) begin
                mant = 64'd1024;
                e++;
            end
            if (e >= 31) return {1'b0, 5'b00101, sgn, 15'h7C00};
            return {1'b0, 4'b0000, ix, sgn, 5'(e), 10'(mant - 64'd1024)};
        end
        return {1'b0, 3'b000, ix, ix, sgn, 15'(mant)};
    endfunction

    // One operation. inject_at >= 0 pulses start (with other operands) at that cycle while busy.
    // start_in_done raises start during the done cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic [4:0] exp_fl, input int exp_lat,
                          input int inject_at, input bit start_in_done);
        int  lat;
        int  extra;
        bit  seen;
        @(negedge clock);
        fpuIn1 = a;
        fpuIn2 = b;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        seen  = 1'b0;
        while (!seen && lat < 40) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (lat == inject_at) begin
                    start  = 1'b1;
                    fpuIn1 = 16'h3C00;
                    fpuIn2 = 16'h0000;
                end
                @(negedge clock);
                start = 1'b0;
                lat++;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " out"}, {16'd0, fpuOut}, {16'd0, exp_res});
        check({tag, " flags"}, {27'd0, statusFlags}, {27'd0, exp_fl});
        check({tag, " cc"}, {28'd0, condCodes}, {28'd0, cc_ref(exp_res)});
        if (start_in_done) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, " pulse"}, {31'd0, done}, 32'd0);
        check({tag, " hold"}, {16'd0, fpuOut}, {16'd0, exp_res});
        if (start_in_done) begin
            extra = 0;
            repeat (20) begin
                @(negedge clock);
                if (done === 1'b1) extra++;
            end
            check({tag, " start in done ignored"}, 32'(extra), 32'd0);
        end
    endtask

    task automatic run_ref(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [21:0] m;
        m = ref_div(a, b);
        run_op(tag, a, b, m[15:0], m[20:16], m[21] ? 1 : 16, -1, 1'b0);
    endtask

    initial begin
        int          dcount;
        logic [15:0] a, b;
        reset  = 1'b1;
        start  = 1'b0;
        fpuIn1 = 16'h0000;
        fpuIn2 = 16'h0000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset out", {16'd0, fpuOut}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset cc", {28'd0, condCodes}, 32'd0);
        check("reset flags", {27'd0, statusFlags}, 32'd0);

        run_op("1/1", 16'h3C00, 16'h3C00, 16'h3C00, 5'b00000, 16, -1, 1'b0);
        run_op("108/9", 16'h56C0, 16'h4880, 16'h4A00, 5'b00000, 16, -1, 1'b0);
        run_op("-1666/119", 16'hE682, 16'h5770, 16'hCB00, 5'b00000, 16, -1, 1'b0);
        run_op("1/3", 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 16, -1, 1'b0);
        run_op("ovf", 16'h7BFF, 16'h1400, 16'h7C00, 5'b00101, 16, -1, 1'b0);
        run_op("1/0", 16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 1, -1, 1'b0);
        run_op("0/0", 16'h0000, 16'h0000, 16'h7E00, 5'b10000, 1, -1, 1'b0);
        run_op("snan", 16'h7D00, 16'h3C00, 16'h7E00, 5'b10000, 1, -1, 1'b0);
        run_op("qnan", 16'h3C00, 16'h7E00, 16'h7E00, 5'b00000, 1, -1, 1'b0);
        run_op("inf/inf", 16'h7C00, 16'hFC00, 16'h7E00, 5'b10000, 1, -1, 1'b0);
        run_op("-inf/2", 16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 1, -1, 1'b0);
        run_op("1/-inf", 16'h3C00, 16'hFC00, 16'h8000, 5'b00000, 1, -1, 1'b0);
        run_op("-0/3", 16'h8000, 16'h4200, 16'h8000, 5'b00000, 1, -1, 1'b0);

        // A prior non-zero result makes the abort-to-zero check meaningful
        run_op("pre-abort", 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 16, -1, 1'b0);
        @(negedge clock);
        fpuIn1 = 16'h3C00;
        fpuIn2 = 16'h4200;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort out", {16'd0, fpuOut}, 32'd0);
        check("abort cc", {28'd0, condCodes}, 32'd0);
        check("abort flags", {27'd0, statusFlags}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        dcount = 0;
        repeat (25) begin
            @(negedge clock);
            if (done === 1'b1) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);
        run_op("1/2 ignore starts", 16'h3C00, 16'h4000, 16'h3800, 5'b00000, 16, 6, 1'b1);

`ifdef FPU_DIV_SUBNORM_EN
        run_op("tiny", 16'h0400, 16'h4000, 16'h0200, 5'b00000, 16, -1, 1'b0);
`else
        run_op("tiny", 16'h0400, 16'h4000, 16'h0000, 5'b00011, 16, -1, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 3 == 1) begin
                a[14:10] = 5'($urandom_range(1, 30));
                b[14:10] = 5'($urandom_range(1, 30));
            end else if (i % 3 == 2) begin
                a[14:10] = 5'($urandom_range(0, 8));
                b[14:10] = 5'($urandom_range(14, 30));
            end
            run_ref($sformatf("rnd%0d %h/%h", i, a, b), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
